seg7_scan_ctrl: RTL



---
 rtl/seg7_scan_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: bus-mapped four-digit seven-segment scan controller.
// VALUE/CTRL registers on the peripheral bus; a prescaled scan walks the
// four digits and drives registered, active-low {an[3:0], seg[7:0]}.

// Per-digit hex decode plus leading-zero blank decision.
module seg7_digit_dec #(
  parameter bit BLANKABLE = 1'b1
) (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       lzb,
  input  logic       zero_above,
  output logic       blank,
  output logic [7:0] seg
);

  // Active-low g..a pattern for the nibble, dp on bit 7.
  always_comb begin
    seg[7] = ~dp;
    case (nib)
      4'h0: seg[6:0] = 7'h40;
      4'h1: seg[6:0] = 7'h79;
      4'h2: seg[6:0] = 7'h24;
      4'h3: seg[6:0] = 7'h30;
      4'h4: seg[6:0] = 7'h19;
      4'h5: seg[6:0] = 7'h12;
      4'h6: seg[6:0] = 7'h02;
      4'h7: seg[6:0] = 7'h78;
      4'h8: seg[6:0] = 7'h00;
      4'h9: seg[6:0] = 7'h10;
      4'hA: seg[6:0] = 7'h08;
      4'hB: seg[6:0] = 7'h03;
      4'hC: seg[6:0] = 7'h46;
      4'hD: seg[6:0] = 7'h21;
      4'hE: seg[6:0] = 7'h06;
      default: seg[6:0] = 7'h0E;
    endcase
  end

  // The rightmost digit is built non-blankable so a zero value still shows "0".
  assign blank = BLANKABLE && lzb && zero_above;

endmodule

module seg7_scan_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h40000010,
  parameter int          SCAN_DIV  = 50000,
  parameter int          DIV_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic [11:0] digits
);

  localparam int                   NUM_DIGITS = 4;
  localparam logic [DIV_WIDTH-1:0] DIV_MAX    = DIV_WIDTH'(SCAN_DIV - 1);

  logic [15:0]          value_q, shadow_q;
  logic                 en_q, lzb_q;
  logic [3:0]           dp_q;
  logic [DIV_WIDTH-1:0] pre_q;
  logic [1:0]           idx_q;

  logic sel_val, sel_ctrl, tick, wrap;
  logic [NUM_DIGITS-1:0][7:0] dig_seg;
  logic [NUM_DIGITS-1:0]      dig_blank;
  logic [NUM_DIGITS-1:0]      zero_above;

  // Bits of the write bus that no register holds.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, Write_data[31:16]};

  assign sel_val  = (Address == BASE_ADDR);
  assign sel_ctrl = (Address == BASE_ADDR + 32'd4);
  assign tick     = en_q && (pre_q == DIV_MAX);
  assign wrap     = tick && (idx_q == 2'd3);

  // Register writes; full-word only, exact address match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      en_q    <= 1'b1;
      lzb_q   <= 1'b0;
      dp_q    <= '0;
    end else if (MemWrite) begin
      if (sel_val) value_q <= Write_data[15:0];
      if (sel_ctrl) begin
        en_q  <= Write_data[0];
        lzb_q <= Write_data[1];
        dp_q  <= Write_data[7:4];
      end
    end
  end

  // Combinational readback; reserved CTRL bits read as zero.
  always_comb begin
    Read_data = '0;
    if (MemRead && sel_val)  Read_data = {16'h0, value_q};
    if (MemRead && sel_ctrl) Read_data = {24'h0, dp_q, 2'b00, lzb_q, en_q};
  end

  // Prescaler and digit index advance only while enabled; both hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (en_q) begin
      if (tick) begin
        pre_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        pre_q <= pre_q + DIV_WIDTH'(1);
      end
    end
  end

  // Frame shadow: latched only at frame start so a frame never tears.
  // Right after reset both VALUE and shadow are zero, so the first frame
  // already matches VALUE without a dedicated load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     shadow_q <= '0;
    else if (wrap) shadow_q <= value_q;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
      assign zero_above[gi] = ~|shadow_q[15:4*gi];
      seg7_digit_dec #(.BLANKABLE(gi != 0)) u_dec (
        .nib        (shadow_q[4*gi+3:4*gi]),
        .dp         (dp_q[gi]),
        .lzb        (lzb_q),
        .zero_above (zero_above[gi]),
        .blank      (dig_blank[gi]),
        .seg        (dig_seg[gi])
      );
    end
  endgenerate

  // Registered drive: one cycle behind index/shadow/CTRL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 digits <= 12'hFFF;
    else if (!en_q)            digits <= 12'hFFF;
    else if (dig_blank[idx_q]) digits <= 12'hFFF;
    else                       digits <= {~(4'b0001 << idx_q), dig_seg[idx_q]};
  end

endmodule
